// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared types and helpers for the data_cache block.
//   state_e       : cache controller states (IDLE/WRITEBACK/FETCH/UPDATE)
//   WORD_W/LINE_W : CPU word width and cache line width
//   OFFSET_W      : byte-offset bits within a line
//   addr_fields_t : CPU byte address split into block / word / byte fields
//   decode_addr   : slices a CPU byte address into addr_fields_t
//   line_word     : selects one 32-bit word from a 128-bit line
// -----------------------------------------------------------------------------
package dcache_pkg;

   localparam int WORD_W   = 32;
   localparam int LINE_W   = 128;
   localparam int OFFSET_W = 4;
   localparam int BLK_W    = WORD_W - OFFSET_W;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      FETCH,
      UPDATE
   } state_e;

   // Block address carries {tag, index}; word selects one of four words.
   typedef struct packed {
      logic [BLK_W-1:0] blk;
      logic [1:0]       word;
      logic [1:0]       byte_off;
   } addr_fields_t;

   function automatic addr_fields_t decode_addr(input logic [WORD_W-1:0] addr);
      return addr_fields_t'(addr);
   endfunction

   // Word 0 lives in bits [31:0] of the line.
   function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        sel);
      return line[{sel, 5'd0} +: WORD_W];
   endfunction

endpackage

// File: rtl/data_cache_if.sv
// -----------------------------------------------------------------------------
// data_cache_if
// Bundles the CPU-side word port and the memory-side block port of data_cache.
//   master : cache view (serves CPU words, initiates block transfers)
//   slave  : environment view (CPU pipeline plus block data memory)
// Signals:
//   cpu_read/cpu_write/cpu_address/cpu_writedata -> cache
//   cpu_readdata/cpu_busywait                    <- cache
//   mem_read/mem_write/mem_address/mem_writedata <- cache
//   mem_readdata/mem_busywait                    -> cache
// -----------------------------------------------------------------------------
interface data_cache_if
   import dcache_pkg::*;
#(
   parameter int MEM_ADDR_W = 28
);

   logic                  cpu_read;
   logic                  cpu_write;
   logic [WORD_W-1:0]     cpu_address;
   logic [WORD_W-1:0]     cpu_writedata;
   logic [WORD_W-1:0]     cpu_readdata;
   logic                  cpu_busywait;

   logic                  mem_read;
   logic                  mem_write;
   logic [MEM_ADDR_W-1:0] mem_address;
   logic [LINE_W-1:0]     mem_writedata;
   logic [LINE_W-1:0]     mem_readdata;
   logic                  mem_busywait;

   modport master (
      input  cpu_read, cpu_write, cpu_address, cpu_writedata,
      input  mem_readdata, mem_busywait,
      output cpu_readdata, cpu_busywait,
      output mem_read, mem_write, mem_address, mem_writedata
   );

   modport slave (
      output cpu_read, cpu_write, cpu_address, cpu_writedata,
      output mem_readdata, mem_busywait,
      input  cpu_readdata, cpu_busywait,
      input  mem_read, mem_write, mem_address, mem_writedata
   );

endinterface

// File: rtl/dcache_line_store.sv
// -----------------------------------------------------------------------------
// dcache_line_store
// Tag, valid, dirty and data arrays of the direct-mapped cache.
// All ports address the same line through idx_i.
//   clock, reset     : clock, async active-high reset (clears valid/dirty)
//   idx_i            : line index
//   tag_o/valid_o/dirty_o/line_o : combinational read of the indexed line
//   word_we_i, word_sel_i, word_data_i : word write, marks the line dirty
//   fill_we_i, fill_data_i             : whole-line data fill
//   tag_we_i, tag_i                    : installs tag, valid = 1, dirty = 0
// -----------------------------------------------------------------------------
module dcache_line_store
   import dcache_pkg::*;
#(
   parameter int SETS  = 8,
   parameter int IDX_W = 3,
   parameter int TAG_W = 25
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [IDX_W-1:0]  idx_i,
   output logic [TAG_W-1:0]  tag_o,
   output logic              valid_o,
   output logic              dirty_o,
   output logic [LINE_W-1:0] line_o,
   input  logic              word_we_i,
   input  logic [1:0]        word_sel_i,
   input  logic [WORD_W-1:0] word_data_i,
   input  logic              fill_we_i,
   input  logic [LINE_W-1:0] fill_data_i,
   input  logic              tag_we_i,
   input  logic [TAG_W-1:0]  tag_i
);

   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [LINE_W-1:0] data_q [SETS];
   logic [SETS-1:0]   valid_q;
   logic [SETS-1:0]   dirty_q;

   assign tag_o   = tag_q[idx_i];
   assign valid_o = valid_q[idx_i];
   assign dirty_o = dirty_q[idx_i];
   assign line_o  = data_q[idx_i];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (tag_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
         end
         if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
         end
      end
   end

   // NOTE: tag and data arrays carry no reset; a line is only ever read
   // through its valid bit, so clearing valid is enough and keeps them RAMs.
   always_ff @(posedge clock) begin
      if (fill_we_i) begin
         data_q[idx_i] <= fill_data_i;
      end
      if (word_we_i) begin
         data_q[idx_i][{word_sel_i, 5'd0} +: WORD_W] <= word_data_i;
      end
      if (tag_we_i) begin
         tag_q[idx_i] <= tag_i;
      end
   end

endmodule

// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
// Direct-mapped, write-back, write-allocate data cache between the MEM stage
// and a 128-bit block memory. Hits are zero-stall; misses stall through
// cpu_busywait while the controller writes back a dirty victim, fetches the
// new line and installs it.
//   clock, reset : clock, async active-high reset
//   bus          : data_cache_if.master (CPU word port + memory block port)
//   hit_count, miss_count : access statistics, present only when
//                  DCACHE_STATS_EN is defined
// -----------------------------------------------------------------------------
module data_cache
   import dcache_pkg::*;
#(
   parameter int SETS       = 8,
   parameter int MEM_ADDR_W = 28
) (
   input  logic         clock,
   input  logic         reset,
   data_cache_if.master bus
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]  hit_count,
   output logic [31:0]  miss_count
`endif
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = MEM_ADDR_W - IDX_W;

   state_e                state_q, state_d;
   logic [MEM_ADDR_W-1:0] miss_blk_q, miss_blk_d;
   logic                  launched_q, launched_d;

   addr_fields_t          cpu_f;
   logic                  access;
   logic                  hit;
   logic [MEM_ADDR_W-1:0] cur_blk;
   logic [IDX_W-1:0]      cur_idx;
   logic [TAG_W-1:0]      cur_tag;
   logic [TAG_W-1:0]      line_tag;
   logic                  line_valid;
   logic                  line_dirty;
   logic [LINE_W-1:0]     line_data;
   logic                  word_we;
   logic                  fill_we;
   logic                  tag_we;
   logic                  unused_byte_off;

   assign cpu_f           = decode_addr(bus.cpu_address);
   assign unused_byte_off = ^cpu_f.byte_off;
   assign access          = bus.cpu_read ^ bus.cpu_write;

   // Outside IDLE the line is addressed by the latched miss block, so a
   // misbehaving CPU cannot redirect an in-flight refill.
   assign cur_blk = (state_q == IDLE) ? cpu_f.blk : miss_blk_q;
   assign cur_idx = cur_blk[IDX_W-1:0];
   assign cur_tag = cur_blk[MEM_ADDR_W-1:IDX_W];
   assign hit     = line_valid && (line_tag == cur_tag);

   assign bus.mem_writedata = line_data;

   dcache_line_store #(
      .SETS  (SETS),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W)
   ) u_store (
      .clock       (clock),
      .reset       (reset),
      .idx_i       (cur_idx),
      .tag_o       (line_tag),
      .valid_o     (line_valid),
      .dirty_o     (line_dirty),
      .line_o      (line_data),
      .word_we_i   (word_we),
      .word_sel_i  (cpu_f.word),
      .word_data_i (bus.cpu_writedata),
      .fill_we_i   (fill_we),
      .fill_data_i (bus.mem_readdata),
      .tag_we_i    (tag_we),
      .tag_i       (cur_tag)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         miss_blk_q <= '0;
         launched_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         miss_blk_q <= miss_blk_d;
         launched_q <= launched_d;
      end
   end

   // launched_q marks that the launch edge of a memory transfer has passed;
   // only later edges with mem_busywait low complete it.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would infer a latch.
      state_d          = state_q;
      miss_blk_d       = miss_blk_q;
      launched_d       = launched_q;
      bus.cpu_readdata = '0;
      bus.cpu_busywait = 1'b0;
      bus.mem_read     = 1'b0;
      bus.mem_write    = 1'b0;
      bus.mem_address  = '0;
      word_we          = 1'b0;
      fill_we          = 1'b0;
      tag_we           = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (access) begin
               if (hit) begin
                  word_we          = bus.cpu_write;
                  bus.cpu_readdata = bus.cpu_read ? line_word(line_data, cpu_f.word) : '0;
               end else begin
                  bus.cpu_busywait = 1'b1;
                  miss_blk_d       = cpu_f.blk;
                  launched_d       = 1'b0;
                  state_d          = (line_valid && line_dirty) ? WRITEBACK : FETCH;
               end
            end
         end
         WRITEBACK: begin
            bus.cpu_busywait = 1'b1;
            bus.mem_write    = 1'b1;
            bus.mem_address  = {line_tag, cur_idx};
            launched_d       = 1'b1;
            if (launched_q && !bus.mem_busywait) begin
               launched_d = 1'b0;
               state_d    = FETCH;
            end
         end
         FETCH: begin
            bus.cpu_busywait = 1'b1;
            bus.mem_read     = 1'b1;
            bus.mem_address  = cur_blk;
            launched_d       = 1'b1;
            if (launched_q && !bus.mem_busywait) begin
               launched_d = 1'b0;
               fill_we    = 1'b1;
               state_d    = UPDATE;
            end
         end
         UPDATE: begin
            bus.cpu_busywait = 1'b1;
            tag_we           = 1'b1;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;
   logic        refill_q;

   // refill_q flags the IDLE cycle right after UPDATE, whose hit is the
   // replay of an access already counted as a miss.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         refill_q   <= 1'b0;
      end else begin
         refill_q <= (state_q == UPDATE);
         if (state_q == IDLE && access) begin
            if (!hit) begin
               miss_cnt_q <= miss_cnt_q + 32'd1;
            end else if (!refill_q) begin
               hit_cnt_q <= hit_cnt_q + 32'd1;
            end
         end
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// -----------------------------------------------------------------------------
// tb_data_cache
// Self-checking bench for data_cache. A block-memory model with a fixed
// busy latency answers the cache; expected load data is queued when a read
// is issued and compared when the cache releases cpu_busywait.
// Define DCACHE_STATS_EN to also check the hit/miss counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_cache;
   import dcache_pkg::*;

   localparam int LAT         = 3;
   localparam int XFER_CYC    = LAT + 1;
   localparam int CLEAN_STALL = 1 + XFER_CYC + 1;
   localparam int DIRTY_STALL = CLEAN_STALL + XFER_CYC;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   data_cache_if #(.MEM_ADDR_W(28)) bus ();

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   data_cache dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   // Block memory model
   logic [LINE_W-1:0] mem_model [256];
   int                mem_cnt;

   assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (mem_cnt < LAT);
   assign bus.mem_readdata = mem_model[bus.mem_address[7:0]];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_cnt <= 0;
      end else if ((bus.mem_read || bus.mem_write) && !bus.mem_busywait) begin
         mem_cnt <= 0;
         if (bus.mem_write) mem_model[bus.mem_address[7:0]] <= bus.mem_writedata;
      end else if (bus.mem_read || bus.mem_write) begin
         mem_cnt <= mem_cnt + 1;
      end
   end

   // Bus monitor
   int          overlap_cnt = 0;
   int          wb_cnt      = 0;
   logic [27:0] wb_addr     = '0;
   logic [27:0] fetch_addr  = '0;
   logic [127:0] wb_data    = '0;

   always @(negedge clk) begin
      if (bus.mem_read && bus.mem_write) overlap_cnt++;
      if (bus.mem_write) begin
         wb_cnt++;
         wb_addr = bus.mem_address;
         wb_data = bus.mem_writedata;
      end
      if (bus.mem_read) fetch_addr = bus.mem_address;
   end

   task automatic clear_mon();
      wb_cnt     = 0;
      wb_addr    = '0;
      wb_data    = '0;
      fetch_addr = '0;
   endtask

   int checks = 0;
   int errors = 0;
   logic [WORD_W-1:0] sb_q [$];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One CPU access held until the cache releases it; stall = busy cycles.
   task automatic access(input bit is_write, input logic [31:0] addr,
                         input logic [31:0] wdata, output int stall);
      logic [WORD_W-1:0] exp;
      @(posedge clk); #1;
      bus.cpu_read      = !is_write;
      bus.cpu_write     = is_write;
      bus.cpu_address   = addr;
      bus.cpu_writedata = wdata;
      stall = 0;
      @(negedge clk);
      while (bus.cpu_busywait && stall < 200) begin
         stall++;
         @(negedge clk);
      end
      check("access_released", 128'(bus.cpu_busywait), '0);
      if (!is_write) begin
         exp = sb_q.pop_front();
         check("load_data", 128'(bus.cpu_readdata), 128'(exp));
      end
      @(posedge clk); #1;
      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;
   endtask

   initial begin
      int stall;
      int waited;
      bus.cpu_read      = 1'b0;
      bus.cpu_write     = 1'b0;
      bus.cpu_address   = '0;
      bus.cpu_writedata = '0;
      for (int i = 0; i < 256; i++) mem_model[i] = '0;
      mem_model[0]  = 128'h0C0C0C0C_0B0B0B0B_0A0A0A0A_09090909;
      mem_model[1]  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
      mem_model[9]  = 128'h99999999_88888888_77777777_66666666;
      mem_model[16] = 128'h44444444_33333333_22222222_11111111;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_busywait", 128'(bus.cpu_busywait), '0);
      check("rst_mem_read", 128'(bus.mem_read), '0);
      check("rst_mem_write", 128'(bus.mem_write), '0);
      check("rst_mem_address", 128'(bus.mem_address), '0);
      check("rst_readdata", 128'(bus.cpu_readdata), '0);
      @(negedge clk);
      rst = 1'b0;

      // Clean read miss
      clear_mon();
      sb_q.push_back(32'hAAAAAAAA);
      access(1'b0, 32'h0000_0010, '0, stall);
      check("s1_stall", 128'(stall), 128'(CLEAN_STALL));
      check("s1_fetch_addr", 128'(fetch_addr), 128'h1);
      check("s1_no_writeback", 128'(wb_cnt), '0);

      // Write hit then read hit
      access(1'b1, 32'h0000_0014, 32'h12345678, stall);
      check("s2_write_stall", 128'(stall), '0);
      sb_q.push_back(32'h12345678);
      access(1'b0, 32'h0000_0014, '0, stall);
      check("s2_read_stall", 128'(stall), '0);

      // Dirty conflict miss
      clear_mon();
      sb_q.push_back(32'h66666666);
      access(1'b0, 32'h0000_0090, '0, stall);
      check("s3_stall", 128'(stall), 128'(DIRTY_STALL));
      check("s3_wb_addr", 128'(wb_addr), 128'h1);
      check("s3_wb_word1", 128'(wb_data[63:32]), 128'h12345678);
      check("s3_wb_line", wb_data, 128'hDDDDDDDD_CCCCCCCC_12345678_AAAAAAAA);
      check("s3_fetch_addr", 128'(fetch_addr), 128'h9);
      check("s3_mem_line1", mem_model[1], 128'hDDDDDDDD_CCCCCCCC_12345678_AAAAAAAA);
      check("s3_rw_exclusive", 128'(overlap_cnt), '0);
`ifdef DCACHE_STATS_EN
      check("stats_hits", 128'(hit_count), 128'd2);
      check("stats_misses", 128'(miss_count), 128'd2);
`endif

      // Write miss allocates, then its dirty line is evicted
      clear_mon();
      access(1'b1, 32'h0000_0104, 32'hCAFEF00D, stall);
      check("s4_write_miss_stall", 128'(stall), 128'(CLEAN_STALL));
      check("s4_fetch_addr", 128'(fetch_addr), 128'h10);
      check("s4_no_writeback", 128'(wb_cnt), '0);
      clear_mon();
      sb_q.push_back(32'h0B0B0B0B);
      access(1'b0, 32'h0000_0008, '0, stall);
      check("s4_evict_stall", 128'(stall), 128'(DIRTY_STALL));
      check("s4_wb_addr", 128'(wb_addr), 128'h10);
      check("s4_wb_line", wb_data, 128'h44444444_33333333_CAFEF00D_11111111);

      // Read and write together is no access
      @(posedge clk); #1;
      bus.cpu_read    = 1'b1;
      bus.cpu_write   = 1'b1;
      bus.cpu_address = 32'h0000_0200;
      @(negedge clk);
      check("s5_busywait", 128'(bus.cpu_busywait), '0);
      check("s5_mem_read", 128'(bus.mem_read), '0);
      @(negedge clk);
      check("s5_mem_idle", 128'({bus.mem_read, bus.mem_write}), '0);
      bus.cpu_read  = 1'b0;
      bus.cpu_write = 1'b0;

      // Reset during a fetch
      sb_q.push_back(32'h66666666);
      access(1'b0, 32'h0000_0090, '0, stall);
      check("s6_prehit_stall", 128'(stall), '0);
      @(posedge clk); #1;
      bus.cpu_read    = 1'b1;
      bus.cpu_address = 32'h0000_0020;
      waited = 0;
      @(negedge clk);
      while (!bus.mem_read && waited < 20) begin
         waited++;
         @(negedge clk);
      end
      check("s6_fetch_started", 128'(bus.mem_read), 128'd1);
      #2 rst = 1'b1;
      #1;
      check("s6_rst_mem_read", 128'(bus.mem_read), '0);
      check("s6_rst_mem_write", 128'(bus.mem_write), '0);
      bus.cpu_read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      sb_q.push_back(32'h66666666);
      access(1'b0, 32'h0000_0090, '0, stall);
      check("s6_invalidated_stall", 128'(stall), 128'(CLEAN_STALL));
      check("s6_rw_exclusive", 128'(overlap_cnt), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage and the 128-bit block data memory.
- Acts as the initiator of the block-memory read/write/busywait protocol. It issues whole-line fetches and write-backs, and serves 32-bit word accesses to the CPU.
- Stalls the pipeline through cpu_busywait on a miss.

Parameters:
- SETS, 8, number of cache lines; must be a power of 2. Index width IDX_W = log2(SETS).
- MEM_ADDR_W, 28, block address width on the memory side (byte address bits [31:4]).
- TAG_W, 28-IDX_W, tag width (25 at default).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- cpu_read  input  1  word read request, held until cpu_busywait is low at a rising edge.
- cpu_write  input  1  word write request, same hold rule.
- cpu_address  input  32  byte address. [3:2] = word, [3+IDX_W:4] = index, [31:4+IDX_W] = tag. [1:0] ignored.
- cpu_writedata  input  32  store data.
- cpu_readdata  output  32  load data; valid while cpu_busywait = 0 on a read.
- cpu_busywait  output  1  stall request to the pipeline.
- mem_read  output  1  block fetch request.
- mem_write  output  1  block write-back request.
- mem_address  output  MEM_ADDR_W  block address = {tag,index}.
- mem_writedata  output  128  victim line; word 0 is in bits [31:0], byte 0 in bits [7:0].
- mem_readdata  input  128  fetched line, same packing.
- mem_busywait  input  1  memory busy; may rise combinationally with mem_read/mem_write.

Behaviour:
- Reset values: state IDLE, all valid = 0, all dirty = 0, mem_read = 0, mem_write = 0, mem_address = 0, cpu_readdata = 0, cpu_busywait = 0.
- Access decode: access = cpu_read XOR cpu_write. Both asserted or both deasserted means no access: cpu_busywait = 0 and no state change.
- Hit = valid[index] && tag[index] == addr tag.
- IDLE, read hit:
  - cpu_readdata = selected word, combinationally.
  - cpu_busywait = 0, so zero-stall.
- IDLE, write hit:
  - cpu_busywait = 0.
  - The word is written and dirty[index] set at the same rising edge.
- IDLE, miss: cpu_busywait = 1 combinationally in the same cycle. At the next edge:
  - go to WRITEBACK if valid && dirty;
  - otherwise go to FETCH.
- WRITEBACK:
  - Outputs: mem_write = 1, mem_address = {stored tag, index}, mem_writedata = stored line.
  - The first edge in this state is the launch edge. At any later edge with mem_busywait = 0, the transfer is complete: go to FETCH.
- FETCH:
  - Outputs: mem_read = 1, mem_address = {cpu tag, index}.
  - Same completion rule as WRITEBACK. On completion go to UPDATE.
  - At the completing edge, capture mem_readdata into the line.
- UPDATE:
  - Set tag, valid = 1, dirty = 0; go to IDLE.
  - mem_read and mem_write are 0.
  - The access then re-resolves as a hit in IDLE. A write hit there sets dirty.
- cpu_busywait stays 1 throughout WRITEBACK, FETCH and UPDATE.
- mem_read and mem_write are never asserted together. They deassert at the same edge that completes the transfer.
- Miss penalty:
  - Clean line: 1 (IDLE) + fetch cycles + 1 (UPDATE).
  - Dirty line: additionally the write-back cycles.
- CPU address or control changes during a stall are a protocol violation; the cache keeps its latched miss address.
- Reset mid-operation: the transfer is abandoned, mem_read and mem_write drop immediately, and all lines are invalidated. The memory is expected to share the same reset.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined:
  - adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0;
  - hit_count increments once per access completing as a first-cycle hit;
  - miss_count increments once per access leaving IDLE on a miss;
  - the post-UPDATE re-resolution is not counted as a hit;
  - both counters wrap at 2^32.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg holds:
  - state enum IDLE/WRITEBACK/FETCH/UPDATE;
  - constants WORD_W = 32, LINE_W = 128, OFFSET_W = 4;
  - the address-field slicing helper functions.
- Sub-module dcache_line_store holds the tag, valid, dirty and data arrays. It has:
  - a combinational read port;
  - a word-write port;
  - a line-fill port;
  - async reset of valid and dirty.
- The FSM and handshake logic stay in data_cache.

Test Plan:
- After reset, read 0x00000010 → miss. FETCH drives mem_address = 0x0000001. On completion with mem_readdata = 0x...DDDDCCCCBBBBAAAA, expect cpu_readdata = 0xAAAAAAAA and cpu_busywait to fall after UPDATE.
- Write 0x12345678 to 0x00000014 (hit) → no stall. A following read of 0x00000014 returns 0x12345678.
- Read 0x00000090 (same index 1, tag 1) → WRITEBACK with mem_address = 0x0000001, mem_writedata[63:32] = 0x12345678. Then FETCH with mem_address = 0x0000009. Only one of mem_read/mem_write is ever high.
- cpu_read = cpu_write = 1 → cpu_busywait = 0 and no mem request.
- Assert reset during FETCH → mem_read drops immediately. Re-reading the previously hit address misses.
- With DCACHE_STATS_EN defined, run the first three scenarios → hit_count = 2, miss_count = 2.
